// File: rtl/dmem_arbiter.sv
// Two-port (CPU / loader) access controller in front of the single-ported DATAMEM.
// Round-robin arbitration, one word access every three cycles, range checking and MEM-stage stall.
module dmem_arbiter #(
   parameter int DEPTH = 50,
   parameter int AW    = 32,
   parameter int DW    = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_ready,
   output logic          cpu_rvalid,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_err,
   output logic          cpu_stall,
   input  logic          ldr_req,
   input  logic          ldr_we,
   input  logic [AW-1:0] ldr_addr,
   input  logic [DW-1:0] ldr_wdata,
   output logic          ldr_ready,
   output logic          ldr_rvalid,
   output logic [DW-1:0] ldr_rdata,
   output logic          ldr_err,
   output logic          mem_read,
   output logic          mem_write,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   localparam logic          CPU     = 1'b0;
   localparam logic          LDR     = 1'b1;
   localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

   state_t        state, state_nxt;
   logic          last_gnt, owner, we_q, err_q;
   logic          cpu_win, ldr_win, accept, sel, sel_we, sel_err;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata, resp_data;

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      cpu_ready = 1'b0;
      ldr_ready = 1'b0;
      // CPU takes a tie only when the loader was served last
      cpu_win   = cpu_req & (~ldr_req | (last_gnt == LDR));
      ldr_win   = ldr_req & ~cpu_win;
      sel       = ldr_win;
      sel_we    = sel ? ldr_we    : cpu_we;
      sel_addr  = sel ? ldr_addr  : cpu_addr;
      sel_wdata = sel ? ldr_wdata : cpu_wdata;
      sel_err   = (sel_addr >= DEPTH_A);
      resp_data = (we_q | err_q) ? '0 : mem_rdata;
      case (state)
         IDLE: begin
            if (cpu_req | ldr_req) begin
               accept    = rst_n;
               cpu_ready = rst_n & cpu_win;
               ldr_ready = rst_n & ldr_win;
               state_nxt = ACCESS;
            end
         end
         ACCESS:  state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_gnt   <= LDR;
         owner      <= CPU;
         we_q       <= 1'b0;
         err_q      <= 1'b0;
         mem_read   <= 1'b0;
         mem_write  <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         cpu_rvalid <= 1'b0;
         cpu_err    <= 1'b0;
         cpu_rdata  <= '0;
         ldr_rvalid <= 1'b0;
         ldr_err    <= 1'b0;
         ldr_rdata  <= '0;
      end else begin
         state      <= state_nxt;
         mem_read   <= 1'b0;
         mem_write  <= 1'b0;
         cpu_rvalid <= 1'b0;
         cpu_err    <= 1'b0;
         cpu_rdata  <= '0;
         ldr_rvalid <= 1'b0;
         ldr_err    <= 1'b0;
         ldr_rdata  <= '0;
         if (accept) begin
            last_gnt  <= sel;
            owner     <= sel;
            we_q      <= sel_we;
            err_q     <= sel_err;
            // address/data registers double as the request latch and hold afterwards
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            mem_read  <= ~sel_we & ~sel_err;
            mem_write <= sel_we & ~sel_err;
         end
         if (state == ACCESS) begin
            if (owner == CPU) begin
               cpu_rvalid <= 1'b1;
               cpu_err    <= err_q;
               cpu_rdata  <= resp_data;
            end else begin
               ldr_rvalid <= 1'b1;
               ldr_err    <= err_q;
               ldr_rdata  <= resp_data;
            end
         end
      end
   end

   assign cpu_stall = cpu_req & ~cpu_rvalid;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port access controller in front of the single-ported `DATAMEM` data memory. It arbitrates between the pipeline MEM stage (CPU port) and the program/data loader (LDR port), then sequences one word access at a time onto the memory strobes. It returns read data and a completion pulse, flags out-of-range addresses, and produces the MEM-stage stall. It sits between the MEM pipeline register and `DATAMEM`.

## Interface
- `DEPTH`, 50, number of words in `DATAMEM`; word-addressed.
- `AW`, 32, address width.
- `DW`, 32, data width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `cpu_req`  in  1  CPU access request; held with its fields until `cpu_rvalid`.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  AW  word address.
- `cpu_wdata`  in  DW  write data.
- `cpu_ready`  out  1  request accepted this cycle; combinational.
- `cpu_rvalid`  out  1  one-cycle completion pulse.
- `cpu_rdata`  out  DW  read data; valid with `cpu_rvalid`.
- `cpu_err`  out  1  address out of range; valid with `cpu_rvalid`.
- `cpu_stall`  out  1  MEM-stage stall; combinational.
- `ldr_req`, `ldr_we`, `ldr_addr`, `ldr_wdata`, `ldr_ready`, `ldr_rvalid`, `ldr_rdata`, `ldr_err`: same directions, widths and meanings as the CPU port. The LDR port has no stall output.
- `mem_read`  out  1  drives `DATAMEM` MemRead; registered.
- `mem_write`  out  1  drives `DATAMEM` MemWrite; registered.
- `mem_addr`  out  AW  drives Addr; registered.
- `mem_wdata`  out  DW  drives Wdata; registered.
- `mem_rdata`  in  DW  from Rdata.

## Operation
FSM states and transitions:
- **IDLE.** If any request is present, pick a winner, assert its `*_ready`, latch `owner`, `we`, `addr`, `wdata`, and set `err = (addr >= DEPTH)`. Go to ACCESS. With no request, stay in IDLE.
- **ACCESS.** One cycle. `mem_read = ~we & ~err`, `mem_write = we & ~err`. `mem_addr` and `mem_wdata` are driven from the latches. Go to RESP.
- **RESP.** One cycle. Strobes are 0. The owner's `*_rvalid` = 1, `*_err` = `err`, and `*_rdata` = the `mem_rdata` sampled at the ACCESS→RESP edge. For writes and for errors, `*_rdata` = 0. Go to IDLE.

Arbitration:
- A lone requester always wins.
- When both request, the port not granted last wins (round-robin).
- `last_gnt` updates at acceptance.
- Out of reset `last_gnt` = LDR, so the CPU wins the first tie.

Other rules:
- An out-of-range access never asserts `mem_read` or `mem_write`. It still completes normally with `err` = 1.
- `*_ready` is only ever high in IDLE, and only for the winner. At most one of `cpu_ready`/`ldr_ready` is high in any cycle.
- `cpu_stall = cpu_req & ~cpu_rvalid`.
- The non-owner port's outputs stay 0 during RESP.

## Timing
- Accept in cycle N → strobe in N+1 → `*_rvalid` in N+2. The earliest next accept is N+3, so one access per 3 cycles.
- Strobes are high for exactly one cycle per accepted in-range access. `mem_read` and `mem_write` are never high together.
- `mem_addr`/`mem_wdata` hold their last value outside ACCESS. Only the strobes are qualified.
- Reset values, applied on any edge with `rst_n` = 0:
  - state = IDLE, `last_gnt` = LDR;
  - `mem_read`, `mem_write`, `mem_addr`, `mem_wdata` = 0;
  - all `*_rvalid`, `*_err`, `*_rdata` = 0.
  - `*_ready` = 0 while `rst_n` = 0.
- Reset mid-operation: the in-flight access is dropped and no `*_rvalid` is issued. A write whose strobe was already high during ACCESS before the reset edge is allowed to have committed.
- A request arriving during ACCESS/RESP waits. It is evaluated on the IDLE cycle, against the updated `last_gnt`.

## Test plan
- **Reset:** hold `rst_n` = 0 for 3 cycles with both reqs high → all outputs 0. After release, the CPU wins first: `cpu_ready` in the first IDLE cycle.
- **Write then read:**
  - LDR write addr 5, data 0xDEADBEEF → `mem_write` = 1 for one cycle at N+1 with `mem_addr` = 5, then `ldr_rvalid` at N+2.
  - Then CPU read addr 5 → `cpu_rdata` = 0xDEADBEEF with `cpu_rvalid`, `cpu_err` = 0.
- **Contention:** both ports hold reads continuously → grants alternate CPU, LDR, CPU, LDR. The `*_rvalid` pulses are spaced 3 cycles apart.
- **Out of range:** CPU read addr 50 (DEPTH) → no strobe in any cycle. `cpu_rvalid` = 1, `cpu_err` = 1, `cpu_rdata` = 0. Addr 49 completes with `cpu_err` = 0.
- **Stall:** CPU req while an LDR access is in ACCESS → `cpu_stall` = 1 every cycle until its own `cpu_rvalid` (4 cycles later), and 0 in that cycle.
- **Reset mid-access:** assert `rst_n` = 0 in the ACCESS cycle of a CPU read → no `cpu_rvalid` ever appears for it. State returns to IDLE and the next request completes with normal latency.
